fft_frame_rx: RTL and testbench
===============================

FFT_FRAME_RX -- requirements
Module: fft_frame_rx

Interface
REQ-001 SHALL have parameter DROP_W, default 8, width of the saturating dropped-frame counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port fft_valid  input  1  one-cycle strobe; a full 16-bin frame is present on fft_d0..fft_d15.
REQ-005 SHALL have ports fft_d0..fft_d15  input  32 each  bin k: real [31:16], imag [15:0], both signed Q8.8.
REQ-006 SHALL have port out_ready  input  1  downstream accepts a beat.
REQ-007 SHALL have port out_valid  output  1  a beat is presented.
REQ-008 SHALL have port out_data  output  32  bin value, same packing as fft_dk.
REQ-009 SHALL have port out_idx  output  4  bin index of the current beat.
REQ-010 SHALL have port out_last  output  1  high on the beat with out_idx=15.
REQ-011 SHALL have port overflow  output  1  one-cycle pulse when a frame is dropped.
REQ-012 SHALL have port drop_cnt  output  DROP_W  number of dropped frames, saturating.
REQ-013 SHALL have port busy  output  1  high when either buffer holds a frame.
REQ-014 SHALL have ports peak_valid (output, 1) and peak_idx (output, 4), present only when FFT_RX_PEAK_EN is defined.

Function
REQ-015 SHALL hold two 16x32 frame buffers (ping-pong), each with a full flag; capture writes one buffer and drain reads the other.
REQ-016 SHALL capture all 16 bins in the cycle fft_valid is sampled high, into the empty buffer; if both are empty, it SHALL use the buffer next in drain order.
REQ-017 SHALL assert out_valid with bin 0 in the cycle after capture (latency 1) when the drain side is idle.
REQ-018 SHALL transfer a beat only when out_valid and out_ready are both high; out_idx SHALL run 0..15 in order and then move to the next full buffer with no idle cycle.
REQ-019 SHALL hold out_data, out_idx and out_last stable while out_valid=1 and out_ready=0.
REQ-020 SHALL free a buffer on the handshake of its out_last beat.
REQ-021 SHALL accept fft_valid arriving while both buffers are full if the out_last handshake occurs in that same cycle.
REQ-022 SHALL otherwise drop a frame arriving while both buffers are full, pulse overflow, increment drop_cnt (holding at all-ones), and leave buffered data untouched.
REQ-023 SHALL use a drain FSM with two states: IDLE (out_valid=0) goes to DRAIN on any full buffer; DRAIN goes to IDLE after the out_last handshake when no other buffer is full.

Reset
REQ-024 SHALL, while rst=1 at a clock edge, clear both full flags, the drain FSM (to IDLE), out_valid, out_idx, out_last, overflow, drop_cnt, busy, peak_valid and peak_idx to 0; out_data SHALL read 0.
REQ-025 SHALL treat reset asserted mid-frame as discarding all buffered data, ignore fft_valid in the reset cycle, and accept a frame in the first cycle after rst falls.

Configuration
REQ-026 SHALL, when FFT_RX_PEAK_EN is defined, compute per beat mag = |re| + |im| as 18-bit unsigned, track the maximum across a frame (ties keep the lower index), pulse peak_valid one cycle after the out_last handshake, and hold peak_idx until the next frame's pulse.
REQ-027 SHALL, when FFT_RX_PEAK_EN is undefined, omit the peak_valid and peak_idx ports and all peak logic.

Structure
REQ-028 SHALL take FRAME_LEN=16, BIN_W=32, IDX_W=4, the drain state enum and the bin real/imag field slicing from the shared package fas_pkg.
REQ-029 SHALL implement the optional peak logic as sub-module fft_peak_track (inputs: beat valid, magnitude source data, idx, last; outputs: peak_valid, peak_idx).

Verification
REQ-030 SHALL verify: one frame with bin k = {k,~k}, out_ready=1 -> out_valid one cycle later, 16 consecutive beats idx 0..15, out_last only on idx 15, busy low after.
REQ-031 SHALL verify: out_ready=0 for 5 cycles at idx 3 -> out_data/out_idx frozen at bin 3, no beat lost or duplicated.
REQ-032 SHALL verify: three frames on consecutive cycles with out_ready=0 -> third dropped, overflow pulses once, drop_cnt=1, frames 1 and 2 drain intact in order.
REQ-033 SHALL verify: a frame arrives exactly on the out_last handshake with both buffers full -> frame accepted, overflow stays 0.
REQ-034 SHALL verify: rst pulsed at idx 7 of a drain -> all outputs 0 next cycle; a new frame afterward drains from idx 0.
REQ-035 SHALL verify, with FFT_RX_PEAK_EN: bin 9 = 0x8000_0100 with all other bins = 0x0010_0010, and bins 4 and 6 tied at max -> peak_idx=9 in the first case and 4 in the tie case.

Source files
------------

// File: rtl/fas_pkg.sv
// Shared definitions for the FFT frame receiver: frame geometry, the drain
// state encoding and helpers that split a packed bin into its Q8.8 parts.
package fas_pkg;

    localparam int FRAME_LEN = 16;
    localparam int BIN_W     = 32;
    localparam int IDX_W     = 4;
    localparam int HALF_W    = 16;
    localparam int MAG_W     = 18;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_t;

    function automatic logic signed [HALF_W-1:0] bin_re(input logic [BIN_W-1:0] b);
        return b[BIN_W-1:HALF_W];
    endfunction

    function automatic logic signed [HALF_W-1:0] bin_im(input logic [BIN_W-1:0] b);
        return b[HALF_W-1:0];
    endfunction

    // |re| + |im|; each absolute value needs 17 bits to hold |-32768|,
    // so the sum needs 18 bits.
    function automatic logic [MAG_W-1:0] bin_mag(input logic [BIN_W-1:0] b);
        logic signed [HALF_W:0] re_x;
        logic signed [HALF_W:0] im_x;
        logic        [HALF_W:0] re_abs;
        logic        [HALF_W:0] im_abs;
        re_x   = {b[BIN_W-1], bin_re(b)};
        im_x   = {b[HALF_W-1], bin_im(b)};
        re_abs = re_x[HALF_W] ? -re_x : re_x;
        im_abs = im_x[HALF_W] ? -im_x : im_x;
        return {1'b0, re_abs} + {1'b0, im_abs};
    endfunction

endpackage

// File: rtl/fft_peak_track.sv
// Tracks the largest |re|+|im| bin across each drained frame and reports its
// index one cycle after the last beat of the frame is accepted.
// Only instantiated when FFT_RX_PEAK_EN is defined.
module fft_peak_track
    import fas_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             beat_valid,
    input  logic [BIN_W-1:0] beat_data,
    input  logic [IDX_W-1:0] beat_idx,
    input  logic             beat_last,
    output logic             peak_valid,
    output logic [IDX_W-1:0] peak_idx
);

    logic [MAG_W-1:0] mag;
    logic [MAG_W-1:0] best_mag;
    logic [IDX_W-1:0] best_idx;
    logic             take;
    logic [IDX_W-1:0] cand_idx;
    logic [MAG_W-1:0] cand_mag;

    assign mag = bin_mag(beat_data);

    // Bin 0 restarts the search; strict compare keeps the lower index on ties.
    always_comb begin
        take     = (beat_idx == '0) || (mag > best_mag);
        cand_mag = take ? mag : best_mag;
        cand_idx = take ? beat_idx : best_idx;
    end

    // Running maximum, plus the registered result pulse at end of frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_mag   <= '0;
            best_idx   <= '0;
            peak_valid <= 1'b0;
            peak_idx   <= '0;
        end else begin
            peak_valid <= beat_valid & beat_last;
            if (beat_valid) begin
                best_mag <= cand_mag;
                best_idx <= cand_idx;
                if (beat_last) begin
                    peak_idx <= cand_idx;
                end
            end
        end
    end

endmodule

// File: rtl/fft_frame_rx.sv
// FFT frame receiver: captures a whole 16-bin frame in one cycle into one of
// two ping-pong buffers and streams it out one bin per ready/valid beat.
// Frames arriving with both buffers occupied are dropped and counted.
// Optional feature macro: FFT_RX_PEAK_EN adds per-frame peak-bin tracking.
module fft_frame_rx
    import fas_pkg::*;
#(
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fft_valid,
    input  logic [BIN_W-1:0]  fft_d0,
    input  logic [BIN_W-1:0]  fft_d1,
    input  logic [BIN_W-1:0]  fft_d2,
    input  logic [BIN_W-1:0]  fft_d3,
    input  logic [BIN_W-1:0]  fft_d4,
    input  logic [BIN_W-1:0]  fft_d5,
    input  logic [BIN_W-1:0]  fft_d6,
    input  logic [BIN_W-1:0]  fft_d7,
    input  logic [BIN_W-1:0]  fft_d8,
    input  logic [BIN_W-1:0]  fft_d9,
    input  logic [BIN_W-1:0]  fft_d10,
    input  logic [BIN_W-1:0]  fft_d11,
    input  logic [BIN_W-1:0]  fft_d12,
    input  logic [BIN_W-1:0]  fft_d13,
    input  logic [BIN_W-1:0]  fft_d14,
    input  logic [BIN_W-1:0]  fft_d15,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [BIN_W-1:0]  out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              busy
`ifdef FFT_RX_PEAK_EN
    ,
    output logic              peak_valid,
    output logic [IDX_W-1:0]  peak_idx
`endif
);

    logic [BIN_W-1:0] din       [FRAME_LEN];
    logic [BIN_W-1:0] frame_buf [2][FRAME_LEN];
    logic [1:0]       full;
    logic             rd_sel;
    drain_state_t     state;

    logic             hs;
    logic             last_hs;
    logic [1:0]       full_free;
    logic [1:0]       full_next;
    logic             next_rd;
    logic             wr_sel;
    logic             accept;
    logic             drop;

    assign din[0]  = fft_d0;
    assign din[1]  = fft_d1;
    assign din[2]  = fft_d2;
    assign din[3]  = fft_d3;
    assign din[4]  = fft_d4;
    assign din[5]  = fft_d5;
    assign din[6]  = fft_d6;
    assign din[7]  = fft_d7;
    assign din[8]  = fft_d8;
    assign din[9]  = fft_d9;
    assign din[10] = fft_d10;
    assign din[11] = fft_d11;
    assign din[12] = fft_d12;
    assign din[13] = fft_d13;
    assign din[14] = fft_d14;
    assign din[15] = fft_d15;

    // Buffer bookkeeping: a buffer freed by this cycle's last beat can take the
    // incoming frame immediately, so occupancy is evaluated after the free.
    always_comb begin
        hs        = out_valid & out_ready;
        last_hs   = hs & out_last;
        full_free = full;
        if (last_hs) begin
            full_free[rd_sel] = 1'b0;
        end
        next_rd   = last_hs ? ~rd_sel : rd_sel;
        accept    = fft_valid & ~(&full_free);
        drop      = fft_valid & (&full_free);
        if (full_free == 2'b00) begin
            wr_sel = next_rd;
        end else begin
            wr_sel = full_free[0];
        end
        full_next = full_free;
        if (accept) begin
            full_next[wr_sel] = 1'b1;
        end
    end

    // Frame capture: all 16 bins land in the chosen buffer in a single cycle.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            for (int k = 0; k < FRAME_LEN; k++) begin
                frame_buf[wr_sel][k] <= din[k];
            end
        end
    end

    // Drain FSM with registered beat controls; rolls straight into the other
    // buffer after a last beat when that buffer is already full.
    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= 2'b00;
            state     <= ST_IDLE;
            rd_sel    <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            full <= full_next;
            case (state)
                ST_IDLE: begin
                    if (|full_next) begin
                        state     <= ST_DRAIN;
                        out_valid <= 1'b1;
                        out_idx   <= '0;
                        out_last  <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (hs) begin
                        if (out_last) begin
                            rd_sel   <= ~rd_sel;
                            out_idx  <= '0;
                            out_last <= 1'b0;
                            if (!full_next[~rd_sel]) begin
                                state     <= ST_IDLE;
                                out_valid <= 1'b0;
                            end
                        end else begin
                            out_idx  <= out_idx + IDX_W'(1);
                            out_last <= (out_idx == IDX_W'(FRAME_LEN - 2));
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Drop reporting and occupancy status.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            overflow <= drop;
            busy     <= |full_next;
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

    assign out_data = out_valid ? frame_buf[rd_sel][out_idx] : '0;

`ifdef FFT_RX_PEAK_EN
    fft_peak_track u_peak (
        .clk        (clk),
        .rst        (rst),
        .beat_valid (hs),
        .beat_data  (out_data),
        .beat_idx   (out_idx),
        .beat_last  (out_last),
        .peak_valid (peak_valid),
        .peak_idx   (peak_idx)
    );
`endif

endmodule

// File: tb/tb_fft_frame_rx.sv
// Testbench for fft_frame_rx: a frame-queue reference model checked every
// cycle, a small vector table for the drop scenario, and directed sequences
// for stall, same-cycle refill, reset and (with FFT_RX_PEAK_EN) peak search.
module tb_fft_frame_rx;

    localparam int DROP_W = 8;

    typedef logic [511:0] frame_t;

    typedef struct {
        bit rst_in;
        bit fv;
        int tag;
        bit rdy;
        bit e_valid;
        int e_idx;
        int e_tag;
        bit e_ovf;
        int e_drop;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              fft_valid;
    logic              out_ready;
    frame_t            in_frame;
    logic [31:0]       fft_d [16];
    logic              out_valid;
    logic [31:0]       out_data;
    logic [3:0]        out_idx;
    logic              out_last;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;
    logic              busy;
`ifdef FFT_RX_PEAK_EN
    logic              peak_valid;
    logic [3:0]        peak_idx;
`endif

    // Reference model state: frames waiting/draining, current beat index.
    frame_t mq[$];
    int     m_idx;
    int     m_drop;
    bit     m_ovf;
    bit     m_pv;
    int     m_pidx;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Fan the packed stimulus frame out to the 16 bin ports.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            fft_d[k] = in_frame[k*32 +: 32];
        end
    end

    fft_frame_rx #(.DROP_W(DROP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .fft_valid (fft_valid),
        .fft_d0    (fft_d[0]),
        .fft_d1    (fft_d[1]),
        .fft_d2    (fft_d[2]),
        .fft_d3    (fft_d[3]),
        .fft_d4    (fft_d[4]),
        .fft_d5    (fft_d[5]),
        .fft_d6    (fft_d[6]),
        .fft_d7    (fft_d[7]),
        .fft_d8    (fft_d[8]),
        .fft_d9    (fft_d[9]),
        .fft_d10   (fft_d[10]),
        .fft_d11   (fft_d[11]),
        .fft_d12   (fft_d[12]),
        .fft_d13   (fft_d[13]),
        .fft_d14   (fft_d[14]),
        .fft_d15   (fft_d[15]),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
`ifdef FFT_RX_PEAK_EN
        ,
        .peak_valid (peak_valid),
        .peak_idx   (peak_idx)
`endif
    );

    function automatic int bin_mag_ref(input logic [31:0] b);
        int re;
        int im;
        re = $signed(b[31:16]);
        im = $signed(b[15:0]);
        return (re < 0 ? -re : re) + (im < 0 ? -im : im);
    endfunction

    // Frame whose bin k is {tag*16+k, ~k}; tag 0 gives the {k, ~k} pattern.
    function automatic frame_t mk_frame(input int tag);
        frame_t f;
        for (int k = 0; k < 16; k++) begin
            f[k*32 +: 32] = {16'(tag * 16 + k), ~16'(k)};
        end
        return f;
    endfunction

    function automatic frame_t rnd_frame();
        frame_t f;
        for (int k = 0; k < 16; k++) begin
            f[k*32 +: 32] = $urandom;
        end
        return f;
    endfunction

    task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the model: drain first, so a freed slot can take a frame.
    task automatic modelStep(input bit r, input bit fv, input frame_t fr, input bit rdy);
        frame_t h;
        int     best;
        int     bk;
        int     m;
        if (r) begin
            mq.delete();
            m_idx  = 0;
            m_drop = 0;
            m_ovf  = 0;
            m_pv   = 0;
            m_pidx = 0;
            return;
        end
        m_pv  = 0;
        m_ovf = 0;
        if (mq.size() > 0 && rdy) begin
            if (m_idx == 15) begin
                h    = mq[0];
                best = -1;
                bk   = 0;
                for (int k = 0; k < 16; k++) begin
                    m = bin_mag_ref(h[k*32 +: 32]);
                    if (m > best) begin
                        best = m;
                        bk   = k;
                    end
                end
                m_pv   = 1;
                m_pidx = bk;
                void'(mq.pop_front());
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        if (fv) begin
            if (mq.size() < 2) begin
                mq.push_back(fr);
            end else begin
                m_ovf = 1;
                if (m_drop < (1 << DROP_W) - 1) m_drop++;
            end
        end
    endtask

    task automatic checkOutput();
        bit     ev;
        frame_t h;
        ev = (mq.size() > 0);
        h  = ev ? mq[0] : '0;
        checkField("out_valid", out_valid, ev);
        checkField("out_idx",   out_idx,   ev ? m_idx : 0);
        checkField("out_last",  out_last,  ev && m_idx == 15);
        checkField("out_data",  out_data,  ev ? h[m_idx*32 +: 32] : 32'h0);
        checkField("overflow",  overflow,  m_ovf);
        checkField("drop_cnt",  drop_cnt,  m_drop);
        checkField("busy",      busy,      ev);
`ifdef FFT_RX_PEAK_EN
        checkField("peak_valid", peak_valid, m_pv);
        checkField("peak_idx",   peak_idx,   m_pidx);
`endif
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic applyStimulus(input bit r, input bit fv, input frame_t fr, input bit rdy);
        rst       = r;
        fft_valid = fv;
        in_frame  = fr;
        out_ready = rdy;
        modelStep(r, fv, fr, rdy);
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idleCycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, rdy);
    endtask

    vec_t   vecs[6];
    frame_t pf;
    int     last_cnt;
    bit     r_rnd;
    bit     fv_rnd;
    bit     rdy_rnd;

    initial begin
        rst       = 1'b1;
        fft_valid = 1'b0;
        out_ready = 1'b0;
        in_frame  = '0;

        vecs[0] = '{0, 1, 1, 0, 1, 0, 1, 0, 0};
        vecs[1] = '{0, 1, 2, 0, 1, 0, 1, 0, 0};
        vecs[2] = '{0, 1, 3, 0, 1, 0, 1, 1, 1};
        vecs[3] = '{0, 0, 0, 0, 1, 0, 1, 0, 1};
        vecs[4] = '{0, 0, 0, 1, 1, 1, 1, 0, 1};
        vecs[5] = '{0, 0, 0, 1, 1, 2, 1, 0, 1};

        // Reset state.
        applyStimulus(1, 0, '0, 0);
        applyStimulus(1, 0, '0, 0);

        // Single frame, always ready: 16 consecutive beats, one last.
        $display("[TB] single frame streaming");
        applyStimulus(0, 1, mk_frame(0), 1);
        last_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (out_valid && out_last) last_cnt++;
            applyStimulus(0, 0, '0, 1);
        end
        checkField("last_count", last_cnt, 1);
        checkField("busy_after", busy, 0);

        // Stall for five cycles on bin 3.
        $display("[TB] stall at idx 3");
        applyStimulus(1, 0, '0, 0);
        applyStimulus(0, 1, mk_frame(4), 1);
        idleCycles(3, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, '0, 0);
            checkField("hold_idx", out_idx, 3);
        end
        idleCycles(14, 1);

        // Third back-to-back frame gets dropped.
        $display("[TB] drop table");
        applyStimulus(1, 0, '0, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].rst_in, vecs[i].fv, mk_frame(vecs[i].tag), vecs[i].rdy);
            pf = mk_frame(vecs[i].e_tag);
            checkField("tbl_valid", out_valid, vecs[i].e_valid);
            checkField("tbl_idx",   out_idx,   vecs[i].e_idx);
            checkField("tbl_data",  out_data,  pf[vecs[i].e_idx*32 +: 32]);
            checkField("tbl_ovf",   overflow,  vecs[i].e_ovf);
            checkField("tbl_drop",  drop_cnt,  vecs[i].e_drop);
        end
        idleCycles(31, 1);
        checkField("tbl_busy_after", busy, 0);

        // Frame arrives on the last-beat handshake with both buffers full.
        $display("[TB] refill on last beat");
        applyStimulus(1, 0, '0, 0);
        applyStimulus(0, 1, mk_frame(5), 0);
        applyStimulus(0, 1, mk_frame(6), 0);
        idleCycles(15, 1);
        checkField("edge_idx", out_idx, 15);
        applyStimulus(0, 1, mk_frame(7), 1);
        checkField("edge_ovf", overflow, 0);
        checkField("edge_drop", drop_cnt, 0);
        idleCycles(33, 1);

        // Reset in the middle of a drain.
        $display("[TB] reset mid-frame");
        applyStimulus(1, 0, '0, 0);
        applyStimulus(0, 1, mk_frame(8), 1);
        idleCycles(7, 1);
        checkField("pre_rst_idx", out_idx, 7);
        applyStimulus(1, 1, mk_frame(9), 1);
        checkField("rst_valid", out_valid, 0);
        checkField("rst_idx",   out_idx,   0);
        checkField("rst_data",  out_data,  0);
        checkField("rst_busy",  busy,      0);
        applyStimulus(0, 1, mk_frame(10), 1);
        pf = mk_frame(10);
        checkField("post_rst_idx",  out_idx,  0);
        checkField("post_rst_data", out_data, pf[31:0]);
        idleCycles(17, 1);

`ifdef FFT_RX_PEAK_EN
        // Peak search: single dominant bin, then a tie.
        $display("[TB] peak tracking");
        applyStimulus(1, 0, '0, 0);
        for (int k = 0; k < 16; k++) pf[k*32 +: 32] = 32'h0010_0010;
        pf[9*32 +: 32] = 32'h8000_0100;
        applyStimulus(0, 1, pf, 1);
        idleCycles(16, 1);
        checkField("peak_pulse", peak_valid, 1);
        checkField("peak_idx9",  peak_idx,   9);
        idleCycles(2, 1);
        checkField("peak_hold",  peak_idx,   9);
        for (int k = 0; k < 16; k++) pf[k*32 +: 32] = 32'h0010_0010;
        pf[4*32 +: 32] = 32'h0200_FE00;
        pf[6*32 +: 32] = 32'hFE00_0200;
        applyStimulus(0, 1, pf, 1);
        idleCycles(16, 1);
        checkField("peak_tie", peak_idx, 4);
        idleCycles(2, 1);
`endif

        // Drop counter saturation.
        $display("[TB] drop saturation");
        applyStimulus(1, 0, '0, 0);
        applyStimulus(0, 1, mk_frame(11), 0);
        applyStimulus(0, 1, mk_frame(12), 0);
        for (int i = 0; i < 260; i++) applyStimulus(0, 1, mk_frame(13), 0);
        checkField("drop_sat", drop_cnt, (1 << DROP_W) - 1);
        idleCycles(33, 1);

        // Randomized traffic against the model.
        $display("[TB] random traffic");
        applyStimulus(1, 0, '0, 0);
        for (int i = 0; i < 1500; i++) begin
            r_rnd   = ($urandom_range(199) == 0);
            fv_rnd  = ($urandom_range(2) == 0);
            rdy_rnd = ($urandom_range(3) != 0);
            applyStimulus(r_rnd, fv_rnd, rnd_frame(), rdy_rnd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
